// File: rtl/station_tx_pkg.sv
// station_tx_pkg: header tag, FSM state encoding and clog2 helper for the station return-path arbiter
package station_tx_pkg;
  localparam logic [3:0] HDR_TAG = 4'hA;
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2, PAD = 2'd3} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/station_tx_arbiter_if.sv
// station_tx_arbiter_if: producer channels, SPI busy handshake and station word output
interface station_tx_arbiter_if #(parameter int NCH = 4, parameter int DW = 16);
  logic [NCH-1:0]    ch_en_i;
  logic [NCH*DW-1:0] ch_data_i;
  logic [NCH-1:0]    ch_dv_i;
  logic [NCH-1:0]    ch_full_o;
  logic [NCH-1:0]    ovf_o;
  logic              busy_i;
  logic [DW-1:0]     data_station_o;
  logic              data_v_station_o;
  logic              timeout_o;
  modport master (
    output ch_en_i, ch_data_i, ch_dv_i, busy_i,
    input  ch_full_o, ovf_o, data_station_o, data_v_station_o, timeout_o
  );
  modport slave (
    input  ch_en_i, ch_data_i, ch_dv_i, busy_i,
    output ch_full_o, ovf_o, data_station_o, data_v_station_o, timeout_o
  );
endinterface

// File: rtl/station_tx_fifo.sv
// station_tx_fifo: per-channel word FIFO with synchronous flush; full and count come straight from registers
module station_tx_fifo
  import station_tx_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                    clk_ref,
  input  logic                    rst_n_o,
  input  logic                    flush,
  input  logic                    write,
  input  logic                    read,
  input  logic [DW-1:0]           din,
  output logic [DW-1:0]           dout,
  output logic [clog2(DEPTH):0]   count,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_wr, do_rd;
  assign full  = count[AW];
  assign empty = count == '0;
  assign dout  = mem[rptr];
  assign do_wr = write & ~flush & (~full | read);
  assign do_rd = read & ~flush & ~empty;
  // pointer and occupancy bookkeeping; a flush empties the channel on the next edge
  always_ff @(posedge clk_ref or negedge rst_n_o)
    if (!rst_n_o) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(do_wr);
      rptr  <= rptr + AW'(do_rd);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  // storage array, no reset needed since reads are gated by count
  always_ff @(posedge clk_ref)
    if (do_wr) mem[wptr] <= din;
endmodule

// File: rtl/station_tx_arbiter.sv
// station_tx_arbiter: buffered round-robin return-path arbiter emitting framed bursts to the SPI station link.
// Optional busy watchdog enabled by defining STATION_TX_WATCHDOG_EN.
module station_tx_arbiter
  import station_tx_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DW       = 16,
  parameter int DEPTH    = 8,
  parameter int MAXBURST = 4,
  parameter int TO_CYC   = 65535
) (
  input logic                 clk_ref,
  input logic                 rst_n_o,
  station_tx_arbiter_if.slave bus
);
  localparam int CW = clog2(DEPTH) + 1;
  localparam int GW = (NCH > 1) ? clog2(NCH) : 1;
  localparam int IW = DW - 12;
  logic [CW-1:0] cnt [NCH];
  logic [DW-1:0] dout [NCH];
  logic [NCH-1:0] full, empty, rd, ovf;
  state_e state;
  logic [GW-1:0] gnt, last, pick;
  logic [7:0] rem, pick_len;
  logic [DW-1:0] dat;
  logic dv, found, emit_ok, pop, wd_hit;
  assign emit_ok = ~bus.busy_i & ~dv;
  assign pop = (state == DATA) & emit_ok & bus.ch_en_i[gnt];
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign rd[c] = pop & (gnt == GW'(c));
    station_tx_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk_ref (clk_ref),
      .rst_n_o (rst_n_o),
      .flush   (~bus.ch_en_i[c]),
      .write   (bus.ch_dv_i[c] & bus.ch_en_i[c]),
      .read    (rd[c]),
      .din     (bus.ch_data_i[c*DW +: DW]),
      .dout    (dout[c]),
      .count   (cnt[c]),
      .full    (full[c]),
      .empty   (empty[c])
    );
  end
  assign bus.ch_full_o        = full;
  assign bus.ovf_o            = ovf;
  assign bus.data_station_o   = dat;
  assign bus.data_v_station_o = dv;
  // round-robin scan from last+1; nearest enabled non-empty channel wins, burst length capped at MAXBURST
  always_comb begin
    found = 1'b0;
    pick  = last;
    for (int i = NCH; i >= 1; i--)
      if (bus.ch_en_i[(int'(last) + i) % NCH] && !empty[(int'(last) + i) % NCH]) begin
        found = 1'b1;
        pick  = GW'((int'(last) + i) % NCH);
      end
    pick_len = (int'(cnt[pick]) > MAXBURST) ? 8'(MAXBURST) : 8'(cnt[pick]);
  end
  // sticky overflow: a write to a full FIFO that is not drained in the same cycle is lost
  always_ff @(posedge clk_ref or negedge rst_n_o)
    if (!rst_n_o) ovf <= '0;
    else ovf <= ovf | (bus.ch_dv_i & bus.ch_en_i & full & ~rd);
  // burst FSM: header then L words; a disabled channel is padded with zeros so the header length stays truthful
  always_ff @(posedge clk_ref or negedge rst_n_o)
    if (!rst_n_o) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= '0;
      rem   <= '0;
      dat   <= '0;
      dv    <= 1'b0;
    end else begin
      dv <= 1'b0;
      if (wd_hit) begin
        state <= IDLE;
        last  <= gnt;
      end else case (state)
        IDLE: if (found) begin
          gnt   <= pick;
          rem   <= pick_len;
          state <= HDR;
        end
        HDR: if (emit_ok) begin
          dat   <= {HDR_TAG, IW'(gnt), rem};
          dv    <= 1'b1;
          state <= DATA;
        end
        DATA, PAD: if (state == DATA && !bus.ch_en_i[gnt]) state <= PAD;
        else if (emit_ok) begin
          dat <= (state == DATA) ? dout[gnt] : '0;
          dv  <= 1'b1;
          rem <= rem - 8'd1;
          if (rem == 8'd1) begin
            state <= IDLE;
            last  <= gnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
`ifdef STATION_TX_WATCHDOG_EN
  logic [31:0] wd;
  logic to_q;
  assign wd_hit = bus.busy_i & (state != IDLE) & (wd == 32'(TO_CYC - 1));
  assign bus.timeout_o = to_q;
  // busy watchdog: counts consecutive busy cycles while a burst is open
  always_ff @(posedge clk_ref or negedge rst_n_o)
    if (!rst_n_o) begin
      wd   <= '0;
      to_q <= 1'b0;
    end else begin
      wd   <= (bus.busy_i && state != IDLE && !wd_hit) ? wd + 32'd1 : '0;
      to_q <= to_q | wd_hit;
    end
`else
  localparam int unused_to_cyc = TO_CYC;
  assign wd_hit = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif
endmodule
